// File: rtl/reduce_cone_pipe.sv
// Pipelined per-channel reduction cone (XOR/MAJ/AND/OR) with popcount,
// valid/ready handshake with full-pipe stall, and a saturating beat counter.
module reduce_cone_pipe #(
  parameter int N_IN   = 8,
  parameter int CH     = 2,
  parameter int STAGES = 3,
  parameter int BC_W   = 16,
  localparam int CW    = $clog2(N_IN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [CH*N_IN-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH-1:0]        out_bit,
  output logic [CH*CW-1:0]     out_count,
  output logic [1:0]           out_mode,
  output logic [BC_W-1:0]      beat_cnt
);

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_MAJ = 2'd1,
    MODE_AND = 2'd2,
    MODE_OR  = 2'd3
  } mode_e;

  function automatic logic [CW-1:0] popcount(input logic [N_IN-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N_IN; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  logic [CH-1:0]    bit_d;
  logic [CH*CW-1:0] cnt_d;

  // The whole reduction is resolved before the first register; later stages
  // only carry the finished result, so mode and count always ride with their beat.
  always_comb begin
    bit_d = '0;
    cnt_d = '0;
    for (int c = 0; c < CH; c++) begin
      cnt_d[c*CW +: CW] = popcount(in_data[c*N_IN +: N_IN]);
      case (mode_e'(in_mode))
        MODE_XOR: bit_d[c] = cnt_d[c*CW];
        MODE_MAJ: bit_d[c] = ({cnt_d[c*CW +: CW], 1'b0} > (CW+1)'(N_IN));
        MODE_AND: bit_d[c] = (cnt_d[c*CW +: CW] == CW'(N_IN));
        MODE_OR:  bit_d[c] = (cnt_d[c*CW +: CW] != '0);
        default:  bit_d[c] = 1'b0;
      endcase
    end
  end

  logic             valid_q [STAGES];
  logic [CH-1:0]    bit_q   [STAGES];
  logic [CH*CW-1:0] cnt_q   [STAGES];
  logic [1:0]       mode_q  [STAGES];
  logic [BC_W-1:0]  beat_q;
  logic             stall;
  logic             accept;

  assign stall    = valid_q[STAGES-1] && !out_ready;
  assign in_ready = rst_n && !stall;
  assign accept   = in_valid && in_ready;

  // A stall freezes every stage, bubbles included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        bit_q[s]   <= '0;
        cnt_q[s]   <= '0;
        mode_q[s]  <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) begin
        bit_q[0]  <= bit_d;
        cnt_q[0]  <= cnt_d;
        mode_q[0] <= in_mode;
      end
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
        bit_q[s]   <= bit_q[s-1];
        cnt_q[s]   <= cnt_q[s-1];
        mode_q[s]  <= mode_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (accept && (beat_q != {BC_W{1'b1}})) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_bit   = bit_q[STAGES-1];
  assign out_count = cnt_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_reduce_cone_pipe.sv
// Self-checking bench for reduce_cone_pipe: vector table, hand sequences for
// stall/reset corners, and random traffic against a queue-based reference model.
module tb_reduce_cone_pipe;

  localparam int N_IN   = 8;
  localparam int CH     = 2;
  localparam int STAGES = 3;
  localparam int CW     = 4;
  localparam int DW     = CH * N_IN;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_mode;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH-1:0]   out_bit;
  logic [CH*CW-1:0] out_count;
  logic [1:0]      out_mode;
  logic [15:0]     beat_cnt;

  logic            sRstN;
  logic            sValid;
  logic            sInReady;
  logic            sOutValid;
  logic [CH-1:0]   sOutBit;
  logic [CH*CW-1:0] sOutCount;
  logic [1:0]      sOutMode;
  logic [3:0]      sBeat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reduce_cone_pipe #(.N_IN(N_IN), .CH(CH), .STAGES(STAGES), .BC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_count(out_count),
    .out_mode(out_mode), .beat_cnt(beat_cnt)
  );

  reduce_cone_pipe #(.N_IN(N_IN), .CH(CH), .STAGES(STAGES), .BC_W(4)) dutSat (
    .clk(clk), .rst_n(sRstN), .in_valid(sValid), .in_ready(sInReady),
    .in_mode(2'd0), .in_data(in_data), .out_valid(sOutValid),
    .out_ready(1'b1), .out_bit(sOutBit), .out_count(sOutCount),
    .out_mode(sOutMode), .beat_cnt(sBeat)
  );

  typedef struct packed {
    logic [1:0]       mode;
    logic [CH-1:0]    bits;
    logic [CH*CW-1:0] cnt;
  } res_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [DW-1:0]    data;
    logic [CH-1:0]    expBit;
    logic [CH*CW-1:0] expCnt;
  } vec_t;

  res_t expQ[$];
  int   expBeats = 0;
  bit   modelOn  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: count ones and apply each mode's rule directly.
  function automatic res_t refModel(input logic [1:0] m, input logic [DW-1:0] d);
    res_t r;
    r.mode = m;
    r.bits = '0;
    r.cnt  = '0;
    for (int c = 0; c < CH; c++) begin
      int p;
      p = $countones(d[c*N_IN +: N_IN]);
      r.cnt[c*CW +: CW] = CW'(p);
      case (m)
        2'd0:    r.bits[c] = (p % 2) == 1;
        2'd1:    r.bits[c] = (2 * p) > N_IN;
        2'd2:    r.bits[c] = (p == N_IN);
        default: r.bits[c] = (p != 0);
      endcase
    end
    return r;
  endfunction

  // Scoreboard: decisions for the coming edge are taken mid-cycle.
  always @(negedge clk) begin
    res_t r;
    if (modelOn) begin
      checkOutput("beat_cnt", 64'(beat_cnt), 64'(expBeats));
      checkOutput("in_ready_rule", 64'(in_ready), 64'(rst_n && !(out_valid && !out_ready)));
    end
    if (!rst_n) begin
      expQ.delete();
      expBeats = 0;
      modelOn  = 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_out: got out_valid with bits %0h expected no result", out_bit);
        end else begin
          r = expQ.pop_front();
          checkOutput("sb_bit",   64'(out_bit),   64'(r.bits));
          checkOutput("sb_count", 64'(out_count), 64'(r.cnt));
          checkOutput("sb_mode",  64'(out_mode),  64'(r.mode));
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refModel(in_mode, in_data));
        if (expBeats < 65535) expBeats++;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [DW-1:0] d, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    checkOutput("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic waitDrain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && expQ.size() != 0; k++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int sent;
    res_t r;

    vecs[0] = '{2'd0, 16'h0FB5, 2'b01, 8'h45};
    vecs[1] = '{2'd1, 16'h0FB5, 2'b01, 8'h45};
    vecs[2] = '{2'd2, 16'h0FB5, 2'b00, 8'h45};
    vecs[3] = '{2'd3, 16'h0FB5, 2'b11, 8'h45};
    vecs[4] = '{2'd2, 16'hFFFF, 2'b11, 8'h88};
    vecs[5] = '{2'd3, 16'h0000, 2'b00, 8'h00};
    vecs[6] = '{2'd1, 16'h1F1F, 2'b11, 8'h55};
    vecs[7] = '{2'd1, 16'h0E1F, 2'b01, 8'h35};
    vecs[8] = '{2'd2, 16'h7FFF, 2'b01, 8'h78};
    vecs[9] = '{2'd3, 16'h8000, 2'b10, 8'h10};

    rst_n = 1'b0; sRstN = 1'b0; sValid = 1'b0;
    in_valid = 1'b0; in_mode = 2'd0; in_data = '0; out_ready = 1'b1;

    $display("[TB] reset then idle");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; sRstN = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
    checkOutput("idle_beat_cnt", 64'(beat_cnt), 64'd0);
    checkOutput("idle_out_bit", 64'(out_bit), 64'd0);

    $display("[TB] mode sweep and boundaries");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].data, lat);
      checkOutput("latency", 64'(lat), 64'(STAGES));
      checkOutput("vec_bit", 64'(out_bit), 64'(vecs[i].expBit));
      checkOutput("vec_count", 64'(out_count), 64'(vecs[i].expCnt));
      checkOutput("vec_mode", 64'(out_mode), 64'(vecs[i].mode));
    end
    waitDrain();

    $display("[TB] backpressure");
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    sent = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (sent < 6);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = DW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (!out_ready) checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    end
    waitDrain();
    checkOutput("bp_sent", 64'(sent), 64'd6);
    checkOutput("bp_beat_cnt", 64'(beat_cnt), 64'd6);

    $display("[TB] reset mid-flight");
    @(posedge clk); #1; in_valid = 1'b1; in_mode = 2'd3; in_data = 16'h1234;
    @(posedge clk); #1; in_data = 16'h5678;
    @(posedge clk); #1; in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    checkOutput("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("midrst_no_out", 64'(out_valid), 64'd0);
    end

    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_mode   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       in_data = '1;
        1:       in_data = '0;
        2:       in_data = {8'h0F, 8'hF0};
        default: in_data = DW'($urandom);
      endcase
    end
    waitDrain();

    $display("[TB] counter saturation");
    in_data = 16'h0FB5;
    @(posedge clk); #1; sValid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      checkOutput("sat_beat_cnt", 64'(sBeat), 64'(i < 15 ? i : 15));
    end
    sValid = 1'b0;
    checkOutput("sat_in_ready", 64'(sInReady), 64'd1);
    repeat (STAGES + 1) @(posedge clk);
    #1;
    r = refModel(2'd0, 16'h0FB5);
    checkOutput("sat_out_valid", 64'(sOutValid), 64'd0);
    checkOutput("sat_out_bit", 64'(sOutBit), 64'(r.bits));
    checkOutput("sat_out_count", 64'(sOutCount), 64'(r.cnt));
    checkOutput("sat_out_mode", 64'(sOutMode), 64'd0);
    checkOutput("sat_hold", 64'(sBeat), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
